wb_arbiter_2m: RTL



---
 rtl/wb_arbiter_2m_if.sv | 51 +++++
 rtl/wb_arbiter_2m.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m_if.sv
// Wishbone bundle between the two CMU masters, the arbiter and the shared system bus.
// The slave modport is the arbiter's view; the master modport is the surrounding masters/bus.
interface wb_arbiter_2m_if;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:2] m0_addr_i;
    logic [2:0]  m0_cti_i;
    logic [1:0]  m0_bte_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_data_i;
    logic [31:0] m0_data_o;
    logic        m0_ack_o, m0_err_o;

    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:2] m1_addr_i;
    logic [2:0]  m1_cti_i;
    logic [1:0]  m1_bte_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_data_i;
    logic [31:0] m1_data_o;
    logic        m1_ack_o, m1_err_o;

    logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [31:2] wbs_addr_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;
    logic [3:0]  wbs_sel_o;
    logic [31:0] wbs_data_o;
    logic [31:0] wbs_data_i;
    logic        wbs_ack_i;
    logic [1:0]  grant;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_cti_i, m0_bte_i, m0_sel_i, m0_data_i,
        output m0_data_o, m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_cti_i, m1_bte_i, m1_sel_i, m1_data_i,
        output m1_data_o, m1_ack_o, m1_err_o,
        output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_addr_o, wbs_cti_o, wbs_bte_o, wbs_sel_o, wbs_data_o,
        input  wbs_data_i, wbs_ack_i,
        output grant
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_cti_i, m0_bte_i, m0_sel_i, m0_data_i,
        input  m0_data_o, m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_cti_i, m1_bte_i, m1_sel_i, m1_data_i,
        input  m1_data_o, m1_ack_o, m1_err_o,
        input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_addr_o, wbs_cti_o, wbs_bte_o, wbs_sel_o, wbs_data_o,
        output wbs_data_i, wbs_ack_i,
        input  grant
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B3 arbiter: grant held for a whole cyc tenure, owner-only return path, slave timeout.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 (data CMU) wins ties.
module wb_arbiter_2m #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_arbiter_2m_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_GRANT0 = 2'b01,
        S_GRANT1 = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [TO_WIDTH-1:0] r_cnt;
    logic                r_err;
    logic                w_tie_m1;
    logic                w_grant_chg;
    logic                w_expire;
    logic                w_cyc;
    logic                w_stb;
    logic [1:0]          w_grant;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic r_last;

    assign w_tie_m1 = ~r_last;

    // Most recently granted master, used only to break ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b0;
        end else if (w_state_next == S_GRANT1) begin
            r_last <= 1'b1;
        end else if (w_state_next == S_GRANT0) begin
            r_last <= 1'b0;
        end else begin
            r_last <= r_last;
        end
    end
`else
    assign w_tie_m1 = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: owner keeps the bus while its cyc is high, then hands straight to a waiting peer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    w_state_next = w_tie_m1 ? S_GRANT1 : S_GRANT0;
                end else if (bus.m0_cyc_i) begin
                    w_state_next = S_GRANT0;
                end else if (bus.m1_cyc_i) begin
                    w_state_next = S_GRANT1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_GRANT0: begin
                if (bus.m0_cyc_i) begin
                    w_state_next = S_GRANT0;
                end else if (bus.m1_cyc_i) begin
                    w_state_next = S_GRANT1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_GRANT1: begin
                if (bus.m1_cyc_i) begin
                    w_state_next = S_GRANT1;
                end else if (bus.m0_cyc_i) begin
                    w_state_next = S_GRANT0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_grant = {(r_state == S_GRANT1), (r_state == S_GRANT0)};
    assign bus.grant = w_grant;

    // Forward path: combinational mux of the owner's request, zero when idle
    always_comb begin
        w_cyc          = 1'b0;
        w_stb          = 1'b0;
        bus.wbs_we_o   = 1'b0;
        bus.wbs_addr_o = 30'h0;
        bus.wbs_cti_o  = 3'b000;
        bus.wbs_bte_o  = 2'b00;
        bus.wbs_sel_o  = 4'h0;
        bus.wbs_data_o = 32'h0;
        case (r_state)
            S_GRANT0: begin
                w_cyc          = bus.m0_cyc_i;
                w_stb          = bus.m0_stb_i;
                bus.wbs_we_o   = bus.m0_we_i;
                bus.wbs_addr_o = bus.m0_addr_i;
                bus.wbs_cti_o  = bus.m0_cti_i;
                bus.wbs_bte_o  = bus.m0_bte_i;
                bus.wbs_sel_o  = bus.m0_sel_i;
                bus.wbs_data_o = bus.m0_data_i;
            end
            S_GRANT1: begin
                w_cyc          = bus.m1_cyc_i;
                w_stb          = bus.m1_stb_i;
                bus.wbs_we_o   = bus.m1_we_i;
                bus.wbs_addr_o = bus.m1_addr_i;
                bus.wbs_cti_o  = bus.m1_cti_i;
                bus.wbs_bte_o  = bus.m1_bte_i;
                bus.wbs_sel_o  = bus.m1_sel_i;
                bus.wbs_data_o = bus.m1_data_i;
            end
            default: begin
                w_cyc = 1'b0;
                w_stb = 1'b0;
            end
        endcase
    end

    // The error cycle also drops cyc/stb so the slave sees the aborted access
    assign bus.wbs_cyc_o = w_cyc & ~r_err;
    assign bus.wbs_stb_o = w_stb & ~r_err;

    assign bus.m0_ack_o  = bus.wbs_ack_i & w_grant[0];
    assign bus.m1_ack_o  = bus.wbs_ack_i & w_grant[1];
    assign bus.m0_data_o = w_grant[0] ? bus.wbs_data_i : 32'h0;
    assign bus.m1_data_o = w_grant[1] ? bus.wbs_data_i : 32'h0;
    assign bus.m0_err_o  = r_err & w_grant[0];
    assign bus.m1_err_o  = r_err & w_grant[1];

    // An ack on the expiry cycle wins; a grant change cancels a pending expiry
    assign w_grant_chg = (w_state_next != r_state);
    assign w_expire    = (r_cnt == TO_WIDTH'(TIMEOUT - 1)) && bus.wbs_stb_o
                         && !bus.wbs_ack_i && !w_grant_chg;

    // Consecutive un-acked strobe counter, saturating at TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_grant_chg || bus.wbs_ack_i || !bus.wbs_stb_o || w_expire) begin
            r_cnt <= '0;
        end else if (r_cnt < TO_WIDTH'(TIMEOUT)) begin
            r_cnt <= r_cnt + TO_WIDTH'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // One-cycle error pulse following the expiry cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_expire;
        end
    end
endmodule
